uart_tx_queue: RTL and testbench

//  Parametrised successor to the char sender: buffered UART transmitter for outgoing decoded

---
 rtl/uart_tx_queue.sv | 130 +++++++++++++
 tb/tb_uart_tx_queue.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_queue.sv
// Buffered UART transmitter: FIFO of outgoing characters serialised back-to-back on TX.
// Push to TX falling edge takes 2 cycles; wr_ready drops when full, and a push while full is dropped and sets overflow.
module uart_tx_queue #(
  parameter int BAUD_DIV  = 868,
  parameter int DATA_BITS = 8,
  parameter int ADDR_W    = 4,
  parameter int PARITY    = 0,
  parameter int STOP_BITS = 1
) (
  input  logic                 cclk,
  input  logic                 rstb,
  input  logic                 wr_ena,
  input  logic [DATA_BITS-1:0] wr_data,
  output logic                 wr_ready,
  input  logic                 flush,
  output logic [ADDR_W:0]      level,
  output logic                 overflow,
  output logic                 tx_busy,
  output logic                 tx_done,
  output logic                 TX
);

  localparam int TW = $clog2(BAUD_DIV);
  localparam int DEPTH = 2 ** ADDR_W;
  localparam logic [ADDR_W:0] FULL_LVL = (ADDR_W + 1)'(DEPTH);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_START = 3'd1;
  localparam logic [2:0] S_DATA  = 3'd2;
  localparam logic [2:0] S_PAR   = 3'd3;
  localparam logic [2:0] S_STOP  = 3'd4;

  logic [ADDR_W:0]      wr_ptr, rd_ptr;
  logic [DATA_BITS-1:0] mem [DEPTH];
  logic [DATA_BITS-1:0] head;
  logic [2:0]           state;
  logic [TW-1:0]        timer;
  logic [3:0]           bit_cnt;
  logic [DATA_BITS-1:0] shreg;
  logic                 par_bit;
  logic                 bit_end, last_data, last_stop;
  logic                 pop, push, line;

  assign level     = wr_ptr - rd_ptr;
  assign wr_ready  = (level != FULL_LVL);
  assign head      = mem[rd_ptr[ADDR_W-1:0]];
  assign bit_end   = (timer == TW'(BAUD_DIV - 1));
  assign last_data = (bit_cnt == 4'(DATA_BITS - 1));
  assign last_stop = (bit_cnt == 4'(STOP_BITS - 1));
  assign tx_done   = (state == S_STOP) && bit_end && last_stop;
  assign tx_busy   = (state != S_IDLE);
  // level is registered, so a push in the last stop cycle is not seen by this pop
  assign pop       = (level != '0) && ((state == S_IDLE) || tx_done);
  assign push      = wr_ena && wr_ready && !flush;

  always_comb begin
    line = 1'b1;
    case (state)
      S_START: line = 1'b0;
      S_DATA:  line = shreg[0];
      S_PAR:   line = par_bit;
      default: line = 1'b1;
    endcase
  end

  always_ff @(posedge cclk) begin
    if (!rstb) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      overflow <= 1'b0;
    end else if (flush) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      overflow <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      if (wr_ena && !wr_ready) overflow <= 1'b1;
    end
  end

  always_ff @(posedge cclk) begin
    if (push) mem[wr_ptr[ADDR_W-1:0]] <= wr_data;
  end

  always_ff @(posedge cclk) begin
    if (!rstb) begin
      state   <= S_IDLE;
      timer   <= '0;
      bit_cnt <= '0;
      shreg   <= '0;
      par_bit <= 1'b0;
      TX      <= 1'b1;
    end else begin
      TX <= line;
      if (state == S_IDLE) timer <= '0;
      else timer <= bit_end ? '0 : timer + 1'b1;
      if (pop) begin
        shreg   <= head;
        par_bit <= (PARITY == 1) ? ~^head : ^head;
      end
      case (state)
        S_IDLE: if (pop) state <= S_START;
        S_START: if (bit_end) begin
          state   <= S_DATA;
          bit_cnt <= '0;
        end
        S_DATA: if (bit_end) begin
          shreg <= shreg >> 1;
          if (last_data) begin
            bit_cnt <= '0;
            state   <= (PARITY != 0) ? S_PAR : S_STOP;
          end else begin
            bit_cnt <= bit_cnt + 1'b1;
          end
        end
        S_PAR: if (bit_end) begin
          state   <= S_STOP;
          bit_cnt <= '0;
        end
        S_STOP: if (bit_end) begin
          if (last_stop) state <= pop ? S_START : S_IDLE;
          else bit_cnt <= bit_cnt + 1'b1;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_queue.sv
// Bench for uart_tx_queue: three parity/stop configurations driven in parallel against a frame-level model.
module tb_uart_tx_queue;

  logic       cclk = 1'b0;
  logic       rstb = 1'b0;
  logic       wr_ena = 1'b0;
  logic       flush = 1'b0;
  logic [7:0] wr_data = 8'h00;

  logic [2:0] lv   [3];
  logic       rdy  [3];
  logic       ovf  [3];
  logic       busy [3];
  logic       done [3];
  logic       tx   [3];

  always #5 cclk = ~cclk;

  uart_tx_queue #(.BAUD_DIV(4), .DATA_BITS(8), .ADDR_W(2), .PARITY(0), .STOP_BITS(1)) u0 (
    .cclk(cclk), .rstb(rstb), .wr_ena(wr_ena), .wr_data(wr_data), .wr_ready(rdy[0]),
    .flush(flush), .level(lv[0]), .overflow(ovf[0]), .tx_busy(busy[0]), .tx_done(done[0]),
    .TX(tx[0]));
  uart_tx_queue #(.BAUD_DIV(4), .DATA_BITS(8), .ADDR_W(2), .PARITY(2), .STOP_BITS(2)) u1 (
    .cclk(cclk), .rstb(rstb), .wr_ena(wr_ena), .wr_data(wr_data), .wr_ready(rdy[1]),
    .flush(flush), .level(lv[1]), .overflow(ovf[1]), .tx_busy(busy[1]), .tx_done(done[1]),
    .TX(tx[1]));
  uart_tx_queue #(.BAUD_DIV(4), .DATA_BITS(8), .ADDR_W(2), .PARITY(1), .STOP_BITS(1)) u2 (
    .cclk(cclk), .rstb(rstb), .wr_ena(wr_ena), .wr_data(wr_data), .wr_ready(rdy[2]),
    .flush(flush), .level(lv[2]), .overflow(ovf[2]), .tx_busy(busy[2]), .tx_done(done[2]),
    .TX(tx[2]));

  int nvec = 0;
  int nerr = 0;

  task automatic chk(input string name, input int act, input int exp);
    nvec++;
    if (act != exp) begin
      nerr++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Model: a byte queue plus the expanded line waveform of the frame on air
  int         par_cfg [3] = '{0, 2, 1};
  int         stop_cfg[3] = '{1, 2, 1};
  logic [7:0] mf   [3][4];
  int         mhead[3];
  int         mcnt [3];
  int         mrem [3];
  int         mflen[3];
  bit         mbits[3][64];
  bit         movf [3];
  bit         mtx  [3];
  bit         model_ok = 1'b0;
  int         busy_cnt[3];
  int         done_cnt[3];

  function automatic void build(input int i, input logic [7:0] b);
    int n;
    bit p;
    n = 0;
    for (int c = 0; c < 4; c++) begin mbits[i][n] = 1'b0; n++; end
    for (int k = 0; k < 8; k++)
      for (int c = 0; c < 4; c++) begin mbits[i][n] = b[k]; n++; end
    if (par_cfg[i] != 0) begin
      p = (par_cfg[i] == 2) ? ^b : ~^b;
      for (int c = 0; c < 4; c++) begin mbits[i][n] = p; n++; end
    end
    for (int c = 0; c < 4 * stop_cfg[i]; c++) begin mbits[i][n] = 1'b1; n++; end
    mflen[i] = n;
  endfunction

  always @(posedge cclk) begin
    int lvl;
    bit pp;
    logic [7:0] b;
    for (int i = 0; i < 3; i++) begin
      if (!rstb) begin
        mcnt[i] = 0; mhead[i] = 0; mrem[i] = 0; movf[i] = 1'b0; mtx[i] = 1'b1;
      end else begin
        lvl = mcnt[i];
        mtx[i] = (mrem[i] != 0) ? mbits[i][mflen[i] - mrem[i]] : 1'b1;
        pp = (lvl != 0) && (mrem[i] <= 1);
        if (mrem[i] != 0) mrem[i]--;
        if (pp) begin
          b = mf[i][mhead[i]];
          mhead[i] = (mhead[i] + 1) % 4;
          mcnt[i]--;
          build(i, b);
          mrem[i] = mflen[i];
        end
        if (flush) begin
          mcnt[i] = 0;
          movf[i] = 1'b0;
        end else if (wr_ena) begin
          if (lvl == 4) movf[i] = 1'b1;
          else begin
            mf[i][(mhead[i] + mcnt[i]) % 4] = wr_data;
            mcnt[i]++;
          end
        end
      end
    end
    if (!rstb) model_ok = 1'b1;
  end

  always @(posedge cclk) begin
    #2;
    if (model_ok) begin
      for (int i = 0; i < 3; i++) begin
        chk($sformatf("level[%0d]", i), int'(lv[i]), mcnt[i]);
        chk($sformatf("wr_ready[%0d]", i), int'(rdy[i]), int'(mcnt[i] != 4));
        chk($sformatf("overflow[%0d]", i), int'(ovf[i]), int'(movf[i]));
        chk($sformatf("tx_busy[%0d]", i), int'(busy[i]), int'(mrem[i] != 0));
        chk($sformatf("tx_done[%0d]", i), int'(done[i]), int'(mrem[i] == 1));
        chk($sformatf("TX[%0d]", i), int'(tx[i]), int'(mtx[i]));
        if (busy[i] === 1'b1) busy_cnt[i]++;
        if (done[i] === 1'b1) done_cnt[i]++;
      end
    end
  end

  task automatic drive(input bit e, input logic [7:0] d, input bit f);
    @(negedge cclk);
    wr_ena  = e;
    wr_data = d;
    flush   = f;
  endtask

  task automatic clr_cnt();
    for (int i = 0; i < 3; i++) begin busy_cnt[i] = 0; done_cnt[i] = 0; end
  endtask

  task automatic wait_idle(input int lim);
    int k;
    k = 0;
    repeat (3) @(negedge cclk);
    while ((busy[0] || busy[1] || busy[2] || lv[0] != 0 || lv[1] != 0 || lv[2] != 0)
           && k < lim) begin
      @(negedge cclk);
      k++;
    end
    if (k >= lim) chk("idle_timeout", 1, 0);
    repeat (2) @(negedge cclk);
  endtask

  // Samples the middle of each bit of the next frame on instance inst
  task automatic capture(input int inst, input int nbits, output bit [15:0] bits);
    int k;
    k = 0;
    bits = '0;
    while (tx[inst] !== 1'b0 && k < 40) begin
      @(negedge cclk);
      k++;
    end
    if (k >= 40) chk("start_timeout", 1, 0);
    repeat (2) @(negedge cclk);
    for (int j = 0; j < nbits; j++) begin
      bits[j] = tx[inst];
      repeat (4) @(negedge cclk);
    end
  endtask

  initial begin
    bit [15:0] fr;
    logic [7:0] d;
    #500000;
    $display("FAIL watchdog: simulation time limit reached, got hang, expected finish");
    $fatal(1);
  end

  initial begin
    bit [15:0] fr;
    logic [7:0] d;
    repeat (3) @(negedge cclk);
    chk("rst_level", int'(lv[0]), 0);
    chk("rst_ready", int'(rdy[0]), 1);
    chk("rst_tx", int'(tx[0]), 1);
    chk("rst_busy", int'(busy[0]), 0);
    rstb = 1'b1;
    repeat (2) @(negedge cclk);

    // single frame, no parity
    clr_cnt();
    drive(1, 8'h41, 0);
    drive(0, 8'h00, 0);
    capture(0, 10, fr);
    chk("t1_frame", int'(fr), 'h282);
    wait_idle(400);
    chk("t1_busy_cycles", busy_cnt[0], 40);
    chk("t1_done_pulses", done_cnt[0], 1);

    // back-to-back frames
    clr_cnt();
    drive(1, 8'h55, 0);
    drive(1, 8'hAA, 0);
    drive(0, 8'h00, 0);
    chk("t2_level_after_pushes", int'(lv[0]), 1);
    wait_idle(400);
    chk("t2_busy_cycles", busy_cnt[0], 80);
    chk("t2_busy_cycles_p2s2", busy_cnt[1], 96);
    chk("t2_done_pulses", done_cnt[0], 2);

    // fill to full, then overflow
    for (int k = 0; k < 5; k++) drive(1, 8'($urandom), 0);
    drive(0, 8'h00, 0);
    chk("t3_level_full", int'(lv[0]), 4);
    chk("t3_ready_low", int'(rdy[0]), 0);
    drive(1, 8'($urandom), 0);
    drive(0, 8'h00, 0);
    chk("t3_overflow", int'(ovf[0]), 1);
    chk("t3_level_stays", int'(lv[0]), 4);
    wait_idle(2000);

    // parity bits and two stop bits
    clr_cnt();
    drive(1, 8'h07, 0);
    drive(0, 8'h00, 0);
    capture(1, 12, fr);
    chk("t4_even_frame", int'(fr), 'hE0E);
    wait_idle(400);
    chk("t4_busy_p2s2", busy_cnt[1], 48);
    drive(1, 8'h07, 0);
    drive(0, 8'h00, 0);
    capture(2, 11, fr);
    chk("t4_odd_frame", int'(fr), 'h40E);
    wait_idle(400);

    // flush during a frame
    chk("t5_overflow_sticky", int'(ovf[0]), 1);
    for (int k = 0; k < 3; k++) drive(1, 8'($urandom), 0);
    drive(0, 8'h00, 0);
    clr_cnt();
    repeat (10) @(negedge cclk);
    drive(0, 8'h00, 1);
    drive(0, 8'h00, 0);
    wait_idle(400);
    chk("t5_level", int'(lv[0]), 0);
    chk("t5_overflow_clear", int'(ovf[0]), 0);
    chk("t5_done_pulses", done_cnt[0], 1);

    // reset in the middle of the data bits
    drive(1, 8'h3C, 0);
    drive(0, 8'h00, 0);
    repeat (20) @(negedge cclk);
    rstb = 1'b0;
    @(negedge cclk);
    rstb = 1'b1;
    chk("t6_tx", int'(tx[0]), 1);
    chk("t6_busy", int'(busy[0]), 0);
    chk("t6_level", int'(lv[0]), 0);
    d = 8'($urandom);
    drive(1, d, 0);
    drive(0, 8'h00, 0);
    capture(0, 10, fr);
    chk("t6_frame", int'(fr), (1 << 9) | (int'(d) << 1));
    wait_idle(400);

    // random traffic with occasional flush
    for (int c = 0; c < 2000; c++)
      drive(($urandom % 3) == 0, 8'($urandom), ($urandom % 97) == 0);
    drive(0, 8'h00, 0);
    wait_idle(2000);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
